// File: rtl/config_loader.sv
// config_loader: serialises host bitstream words onto the configuration chain.
// Each accepted word is shifted out MSB-first with one chain_en pulse per bit
// until CHAIN_LEN bits have been sent; surplus low bits of the last word are dropped.
// Optional build macro CONFIG_CRC_EN adds a CRC-8 (poly 0x07) check against a
// trailer word accepted after the last chain bit.
module config_loader #(
  parameter int  CHAIN_LEN = 96,
  parameter int  WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              config_clk,
  input  logic              sys_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              chain_in,
  output logic              chain_en,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
`ifdef CONFIG_CRC_EN
  localparam logic [2:0] S_CHECK = 3'd3;
`endif
  localparam logic [2:0] S_FIN   = 3'd4;

  // word_cnt indexes the bit of the current word now on chain_in
  localparam int               WC_W      = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [WC_W-1:0]  WORD_LAST = WC_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CHAIN_LEN - 1);

  logic [2:0]        state;
  logic [WORD_W-1:0] sreg;
  logic [WC_W-1:0]   word_cnt;

  logic word_accept;
  assign word_accept = (state == S_FETCH) && wr_valid && wr_ready;

`ifdef CONFIG_CRC_EN
  logic [7:0] crc;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  // Running CRC over every bit actually clocked into the chain
  always_ff @(posedge config_clk) begin
    if (state == S_IDLE && start) begin
      crc <= 8'h00;
    end else if (state == S_SHIFT) begin
      crc <= crc8_step(crc, chain_in);
    end
  end
`endif

  // Word shift register and in-word bit index; chain_in is fed from its MSB
  always_ff @(posedge config_clk) begin
    if (word_accept) begin
      sreg     <= wr_data << 1;
      word_cnt <= '0;
    end else if (state == S_SHIFT) begin
      sreg     <= sreg << 1;
      word_cnt <= word_cnt + 1'b1;
    end
  end

  // Load sequencer: all outputs are registered and reflect the state they belong to
  always_ff @(posedge config_clk) begin
    if (sys_reset) begin
      state     <= S_IDLE;
      wr_ready  <= 1'b0;
      chain_in  <= 1'b0;
      chain_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      bit_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            wr_ready  <= 1'b1;
            busy      <= 1'b1;
            bit_count <= '0;
            error     <= 1'b0;
          end
        end
        S_FETCH: begin
          if (word_accept) begin
            state    <= S_SHIFT;
            wr_ready <= 1'b0;
            chain_en <= 1'b1;
            chain_in <= wr_data[WORD_W-1];
          end
        end
        S_SHIFT: begin
          // the bit on chain_in is clocked into the chain at this edge
          bit_count <= bit_count + 1'b1;
          if (bit_count == CNT_LAST) begin
            chain_en <= 1'b0;
`ifdef CONFIG_CRC_EN
            state    <= S_CHECK;
            wr_ready <= 1'b1;
`else
            state    <= S_FIN;
            done     <= 1'b1;
            busy     <= 1'b0;
`endif
          end else if (word_cnt == WORD_LAST) begin
            chain_en <= 1'b0;
            state    <= S_FETCH;
            wr_ready <= 1'b1;
          end else begin
            chain_in <= sreg[WORD_W-1];
          end
        end
`ifdef CONFIG_CRC_EN
        S_CHECK: begin
          // trailer word is compared only, never shifted into the chain
          if (wr_valid && wr_ready) begin
            wr_ready <= 1'b0;
            error    <= (wr_data[7:0] != crc);
            state    <= S_FIN;
            done     <= 1'b1;
            busy     <= 1'b0;
          end
        end
`endif
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
